// File: rtl/uart_rcv_ctrl.sv
// Receive-side control FSM for the async serial receiver: steers the external bit timer,
// samples on its rollover pulse, and holds the received word with ready/overrun/framing status.
`timescale 1ns/1ps

module uart_rcv_ctrl #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 bit_tick,
    output logic                 timer_clear,
    output logic                 timer_enable,
    output logic                 half_sel,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    input  logic                 data_read,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START_CHK = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_LOAD      = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 s_prev_q, s_prev_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 overrun_q, overrun_d;
    logic                 framing_q, framing_d;
    logic                 clr_pulse_q, clr_pulse_d;
    logic                 s_in;

    assign s_in = sync2_q;

    always_comb begin
        sync1_d      = serial_in;
        sync2_d      = sync1_q;
        s_prev_d     = sync2_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;
        framing_d    = framing_q;
        clr_pulse_d  = 1'b0;

        if (data_read) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_prev_q && !s_in) begin
                    state_d   = ST_START_CHK;
                    framing_d = 1'b0;
                end
            end
            ST_START_CHK: begin
                if (bit_tick) begin
                    if (!s_in) begin
                        state_d     = ST_DATA;
                        bit_cnt_d   = '0;
                        // Restart the full-period count from mid-start-bit.
                        clr_pulse_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = {s_in, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (s_in) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d   = ST_IDLE;
                        framing_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                rx_data_d    = shift_q;
                data_ready_d = 1'b1;
                if (data_ready_q && !data_read) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            s_prev_q     <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
            clr_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            s_prev_q     <= s_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            framing_q    <= framing_d;
            clr_pulse_q  <= clr_pulse_d;
        end
    end

    assign timer_clear   = (state_q == ST_IDLE) || (state_q == ST_LOAD) || clr_pulse_q;
    assign timer_enable  = (state_q == ST_START_CHK) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign half_sel      = (state_q == ST_IDLE) || (state_q == ST_START_CHK) || (state_q == ST_LOAD);
    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rcv_ctrl.sv
// Directed bench for uart_rcv_ctrl with a behavioural bit timer (5 clks half period, 10 clks full).
`timescale 1ns/1ps

module tb_uart_rcv_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       bit_tick = 1'b0;
    logic       data_read = 1'b0;
    logic       timer_clear, timer_enable, half_sel;
    logic [7:0] rx_data;
    logic       data_ready, overrun_error, framing_error;

    int n_checks = 0;
    int n_errors = 0;
    int tcnt = 0;

    uart_rcv_ctrl #(.DATA_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .bit_tick      (bit_tick),
        .timer_clear   (timer_clear),
        .timer_enable  (timer_enable),
        .half_sel      (half_sel),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .data_read     (data_read),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    // Bit timer: one-cycle tick every 5 (half) or 10 (full) enabled clocks after a clear.
    always @(posedge clk) begin
        if (timer_clear === 1'b1) begin
            tcnt     <= 0;
            bit_tick <= 1'b0;
        end else if (timer_enable === 1'b1) begin
            if (tcnt + 1 == ((half_sel === 1'b1) ? 5 : 10)) begin
                tcnt     <= 0;
                bit_tick <= 1'b1;
            end else begin
                tcnt     <= tcnt + 1;
                bit_tick <= 1'b0;
            end
        end else begin
            bit_tick <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status(input string tag, input logic [7:0] exp_data, input logic exp_rdy,
                                input logic exp_ovr, input logic exp_fe);
        chk({tag, ".rx_data"}, {1'b0, rx_data}, {1'b0, exp_data});
        chk({tag, ".data_ready"}, {8'd0, data_ready}, {8'd0, exp_rdy});
        chk({tag, ".overrun"}, {8'd0, overrun_error}, {8'd0, exp_ovr});
        chk({tag, ".framing"}, {8'd0, framing_error}, {8'd0, exp_fe});
    endtask

    task automatic check_timer(input string tag, input logic clr, input logic en, input logic half);
        chk({tag, ".timer_clear"}, {8'd0, timer_clear}, {8'd0, clr});
        chk({tag, ".timer_enable"}, {8'd0, timer_enable}, {8'd0, en});
        chk({tag, ".half_sel"}, {8'd0, half_sel}, {8'd0, half});
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        tick_n(1);
        data_read = 1'b0;
    endtask

    // Start bit falls at cycle 0 after a 5-cycle idle gap; each bit lasts 10 clocks.
    // Returns 2 cycles after the stop bit ends, when the loaded word is visible.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_at_load,
                              input logic probe);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        serial_in = 1'b1;
        tick_n(5);
        for (int k = 0; k < 100; k++) begin
            serial_in = bits[k/10];
            if (probe && k == 5)  check_timer("start_chk", 1'b0, 1'b1, 1'b1);
            if (probe && k == 9)  check_timer("data_first", 1'b1, 1'b1, 1'b0);
            if (probe && k == 10) check_timer("data_second", 1'b0, 1'b1, 1'b0);
            tick_n(1);
        end
        serial_in = 1'b1;
        tick_n(1);
        data_read = rd_at_load;
        tick_n(1);
        data_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick_n(3);
        rst = 1'b0;
        check_status("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check_timer("reset", 1'b1, 1'b0, 1'b1);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check_status("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        pulse_read();
        check_status("read_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        pulse_read();
        check_status("read_idle_noop", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Short low glitch: start check sees the line high again at mid-bit.
        tick_n(5);
        serial_in = 1'b0;
        tick_n(3);
        serial_in = 1'b1;
        tick_n(2);
        check_timer("glitch_chk", 1'b0, 1'b1, 1'b1);
        tick_n(10);
        check_timer("glitch_idle", 1'b1, 1'b0, 1'b1);
        check_status("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_status("framing_3c", 8'hA5, 1'b0, 1'b0, 1'b1);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        check_status("frame_11", 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check_status("overrun_22", 8'h22, 1'b1, 1'b1, 1'b0);
        pulse_read();
        check_status("read_22", 8'h22, 1'b0, 1'b0, 1'b0);

        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        check_status("frame_33", 8'h33, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        check_status("read_in_load_5a", 8'h5A, 1'b1, 1'b0, 1'b0);
        pulse_read();
        check_status("read_5a", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 of a frame.
        serial_in = 1'b1;
        tick_n(5);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h5A, 1'b0};
            for (int k = 0; k < 55; k++) begin
                serial_in = bits[k/10];
                tick_n(1);
            end
        end
        check_timer("mid_data", 1'b0, 1'b1, 1'b0);
        serial_in = 1'b1;
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        check_status("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        check_timer("reset_mid", 1'b1, 1'b0, 1'b1);
        tick_n(20);
        check_status("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check_status("frame_ff", 8'hFF, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
